uart_stream_echo: RTL and testbench
===================================

# uart_stream_echo

User-side endpoint for the UART Avalon-ST streams: consumes received bytes from the UART's from_uart source, buffers them in a FIFO, optionally folds lowercase letters to uppercase and expands CR to CR LF, then returns them on the UART's to_uart sink. It sits beside the UART system, wired directly to its rs232_0_from_uart_* and rs232_0_to_uart_* ports, and gives the board a terminal echo with a receive-error counter.

## Interface
- FIFO_DEPTH, 16, byte FIFO depth; power of two, ≥ 4
- UPPERCASE, 1, 1 = map 0x61–0x7A to 0x41–0x5A on egress
- CRLF_EXPAND, 1, 1 = emit 0x0A immediately after every egressed 0x0D
- clk_clk  input  1  single system clock, all logic rising-edge
- reset_reset_n  input  1  asynchronous, active-low reset
- from_uart_data  input  8  received byte
- from_uart_valid  input  1  received byte valid
- from_uart_error  input  1  framing/parity error on this beat
- from_uart_ready  output  1  sink ready (readyLatency 0)
- to_uart_data  output  8  byte to transmit
- to_uart_valid  output  1  byte valid
- to_uart_error  output  1  constant 0
- to_uart_ready  input  1  UART transmitter ready (readyLatency 0)
- err_count  output  8  saturating count of errored beats
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Ingress: from_uart_ready = !full. Beat accepted when valid & ready. Accepted beat with error=1: byte dropped, err_count += 1 saturating at 255. Otherwise byte written to FIFO.
- FIFO: read/write pointers with one extra wrap bit; full when pointer MSBs differ and lower bits match; empty when equal. Write blocked when full even if a pop occurs the same cycle.
- Egress FSM, states IDLE, SEND, SEND_LF:
  - IDLE: if FIFO non-empty, pop into hold register (transform applied at pop), go SEND.
  - SEND: to_uart_valid=1, to_uart_data=hold. On to_uart_ready: if hold==0x0D and CRLF_EXPAND, go SEND_LF; else if FIFO non-empty pop next into hold and stay SEND; else IDLE.
  - SEND_LF: to_uart_valid=1, data 0x0A. On ready: pop-or-IDLE as in SEND.
- valid and data held stable until ready; never deasserted without a handshake.
- Transform applied to hold only; FIFO stores raw bytes.

## Timing
- Reset values: to_uart_valid 0, to_uart_data 0x00, to_uart_error 0, err_count 0, fifo_level 0, from_uart_ready 1 (FIFO empty), FSM IDLE.
- Reset mid-operation: FIFO contents discarded, pending hold byte and pending LF lost, err_count cleared.
- Latency: byte accepted in cycle N appears on to_uart_data with valid in cycle N+2 (FIFO write N, pop N+1, hold valid N+2) when FSM is IDLE.
- Back-to-back: with ready held 1 and FIFO non-empty, one byte per cycle; CR costs one extra cycle for LF.
- Simultaneous push and pop: allowed when not full; fifo_level unchanged.
- err_count at 255 stays 255.

## Structure
- Package uart_echo_pkg: ASCII_CR (8'h0D), ASCII_LF (8'h0A), ASCII_a/z, CASE_OFFSET (8'h20), egress state enum.
- Sub-module uart_byte_fifo: synchronous FIFO, parameter DEPTH, push/pop/full/empty/level; top holds ingress filter, egress FSM, transform and counter.

## Test plan
- Send 0x61,0x42,0x7A with to_uart_ready=1 -> egress 0x41,0x42,0x5A, first byte valid 2 cycles after accept.
- Send 0x0D then 0x31 -> egress 0x0D,0x0A,0x31; with CRLF_EXPAND=0 -> 0x0D,0x31.
- Hold to_uart_ready=0, send 20 bytes (DEPTH 16) -> from_uart_ready drops after 16 stored (+1 in hold = 17 accepted), fifo_level=16, no loss; release ready -> all 17 out in order.
- Send 3 beats with error=1 among 0x55 beats -> errored bytes absent from egress, err_count=3; 300 errored beats -> err_count=255.
- Assert reset_reset_n=0 mid-stream with FIFO at 5 -> outputs to reset values immediately, after release fifo_level=0 and no stale byte emitted.
- Random valid/ready throttling, 2000 bytes -> egress equals scoreboard model, valid/data stable while ready=0.

Source files
------------

// File: rtl/uart_echo_pkg.sv
// Shared constants, egress state encoding and the case-fold helper for the
// UART stream echo endpoint.
package uart_echo_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] ASCII_CR    = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF    = 8'h0A;
  localparam logic [BYTE_W-1:0] ASCII_a     = 8'h61;
  localparam logic [BYTE_W-1:0] ASCII_z     = 8'h7A;
  localparam logic [BYTE_W-1:0] CASE_OFFSET = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_SEND_LF = 2'd2
  } egress_state_e;

  // Lowercase ASCII letters become uppercase; every other byte passes through.
  function automatic logic [BYTE_W-1:0] fold_upper(input logic [BYTE_W-1:0] b);
    return ((b >= ASCII_a) && (b <= ASCII_z)) ? (b - CASE_OFFSET) : b;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers and show-ahead read data.
module uart_byte_fifo
  import uart_echo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic [BYTE_W-1:0]       wdata_i,
  input  logic                    pop_i,
  output logic [BYTE_W-1:0]       rdata_c_o,
  output logic                    full_c_o,
  output logic                    empty_c_o,
  output logic [$clog2(DEPTH):0]  level_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC = (AW+1)'(1);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
  assign full_c_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_c_o = (wr_ptr_q == rd_ptr_q);
  assign do_push   = push_i && !full_c_o;
  assign do_pop    = pop_i && !empty_c_o;

  assign wr_ptr_d  = do_push ? (wr_ptr_q + PTR_INC) : wr_ptr_q;
  assign rd_ptr_d  = do_pop  ? (rd_ptr_q + PTR_INC) : rd_ptr_q;
  assign rdata_c_o = mem_q[rd_ptr_q[AW-1:0]];
  assign level_c_o = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: occupancy is defined by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_stream_echo.sv
// Terminal echo between the UART Avalon-ST source and sink: ingress error
// filter, byte FIFO, egress FSM with optional upper-casing and CR->CRLF.
module uart_stream_echo
  import uart_echo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter bit          UPPERCASE   = 1'b1,
  parameter bit          CRLF_EXPAND = 1'b1
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [BYTE_W-1:0]             from_uart_data,
  input  logic                          from_uart_valid,
  input  logic                          from_uart_error,
  output logic                          from_uart_ready,
  output logic [BYTE_W-1:0]             to_uart_data,
  output logic                          to_uart_valid,
  output logic                          to_uart_error,
  input  logic                          to_uart_ready,
  output logic [BYTE_W-1:0]             err_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  egress_state_e     state_q, state_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [BYTE_W-1:0] err_cnt_q, err_cnt_d;

  logic              accept;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_rdata;
  logic [BYTE_W-1:0] next_byte;
  logic              advance;

  // Ingress: errored beats are consumed but never stored.
  assign from_uart_ready = !fifo_full;
  assign accept          = from_uart_valid && from_uart_ready;
  assign fifo_push       = accept && !from_uart_error;

  assign err_cnt_d = (accept && from_uart_error && (err_cnt_q != 8'hFF))
                     ? (err_cnt_q + 8'd1) : err_cnt_q;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_clk),
    .rst_ni    (reset_reset_n),
    .push_i    (fifo_push),
    .wdata_i   (from_uart_data),
    .pop_i     (fifo_pop),
    .rdata_c_o (fifo_rdata),
    .full_c_o  (fifo_full),
    .empty_c_o (fifo_empty),
    .level_c_o (fifo_level)
  );

  // The FIFO keeps raw bytes; case folding happens on the way into the hold register.
  assign next_byte = UPPERCASE ? fold_upper(fifo_rdata) : fifo_rdata;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    fifo_pop = 1'b0;
    advance  = 1'b0;

    unique case (state_q)
      ST_IDLE: advance = 1'b1;
      ST_SEND: begin
        if (to_uart_ready) begin
          if (CRLF_EXPAND && (data_q == ASCII_CR)) begin
            state_d = ST_SEND_LF;
            data_d  = ASCII_LF;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_SEND_LF: advance = to_uart_ready;
      default: state_d = ST_IDLE;
    endcase

    // Load the next byte straight into hold so a busy stream costs no bubble.
    if (advance) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        data_d   = next_byte;
        valid_d  = 1'b1;
        state_d  = ST_SEND;
      end else begin
        valid_d  = 1'b0;
        state_d  = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign to_uart_data  = data_q;
  assign to_uart_valid = valid_q;
  assign to_uart_error = 1'b0;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_uart_stream_echo.sv
// Self-checking bench for uart_stream_echo: vector table, corner sequences
// and a queue scoreboard on the egress stream.
module tb_uart_stream_echo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;

  logic [7:0]    in_data;
  logic          in_valid, in_err, in_ready;
  logic [7:0]    out_data;
  logic          out_valid, out_err, out_ready;
  logic [7:0]    err_count;
  logic [LW-1:0] level;

  logic [7:0]    r_in_data;
  logic          r_in_valid, r_in_err, r_in_ready;
  logic [7:0]    r_out_data;
  logic          r_out_valid, r_out_err, r_out_ready;
  logic [7:0]    r_err_count;
  logic [LW-1:0] r_level;

  assign r_out_ready = 1'b1;

  uart_stream_echo #(.FIFO_DEPTH(DEPTH), .UPPERCASE(1'b1), .CRLF_EXPAND(1'b1)) u_dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .from_uart_data  (in_data),
    .from_uart_valid (in_valid),
    .from_uart_error (in_err),
    .from_uart_ready (in_ready),
    .to_uart_data    (out_data),
    .to_uart_valid   (out_valid),
    .to_uart_error   (out_err),
    .to_uart_ready   (out_ready),
    .err_count       (err_count),
    .fifo_level      (level)
  );

  uart_stream_echo #(.FIFO_DEPTH(DEPTH), .UPPERCASE(1'b0), .CRLF_EXPAND(1'b0)) u_dut_raw (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .from_uart_data  (r_in_data),
    .from_uart_valid (r_in_valid),
    .from_uart_error (r_in_err),
    .from_uart_ready (r_in_ready),
    .to_uart_data    (r_out_data),
    .to_uart_valid   (r_out_valid),
    .to_uart_error   (r_out_err),
    .to_uart_ready   (r_out_ready),
    .err_count       (r_err_count),
    .fifo_level      (r_level)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         ready_mode = 1;  // 0 = hold low, 1 = hold high, 2 = random
  logic [7:0] exp_q[$];
  logic [7:0] rexp_q[$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    bit         lf;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour of the default-configured endpoint for one stored byte.
  task automatic expect_main(input logic [7:0] b);
    logic [7:0] o;
    o = ((b >= 8'h61) && (b <= 8'h7A)) ? (b - 8'h20) : b;
    exp_q.push_back(o);
    if (o == 8'h0D) exp_q.push_back(8'h0A);
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Egress scoreboard plus hold-stability check while the sink stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(stall_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_egress: got 0x%0h, want nothing", out_data);
        end else begin
          check("egress", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      stall_q    <= out_valid && !out_ready;
      stall_data <= out_data;
    end
  end

  always @(negedge clk) begin
    if (rst_n && r_out_valid) begin
      if (rexp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_raw_egress: got 0x%0h, want nothing", r_out_data);
      end else begin
        check("raw_egress", 32'(r_out_data), 32'(rexp_q.pop_front()));
      end
    end
  end

  // Drive one beat and wait (bounded) for the sink to take it.
  task automatic send(input bit raw, input logic [7:0] b, input logic e);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    @(posedge clk);
    #1;
    if (raw) begin
      r_in_valid = 1'b1; r_in_data = b; r_in_err = e;
    end else begin
      in_valid = 1'b1; in_data = b; in_err = e;
    end
    while (!done) begin
      @(negedge clk);
      if (raw ? r_in_ready : in_ready) begin
        done = 1'b1;
      end else if (++n > 200) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got no ready, want ready within 200 cycles");
        done = 1'b1;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    r_in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || (rexp_q.size() != 0)) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 32'(exp_q.size() + rexp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         nacc;
    logic [7:0] b;
    logic       e;

    vecs[0] = '{8'h42, 8'h42, 1'b0};
    vecs[1] = '{8'h7A, 8'h5A, 1'b0};
    vecs[2] = '{8'h0D, 8'h0D, 1'b1};
    vecs[3] = '{8'h31, 8'h31, 1'b0};
    vecs[4] = '{8'h60, 8'h60, 1'b0};
    vecs[5] = '{8'h7B, 8'h7B, 1'b0};
    vecs[6] = '{8'h41, 8'h41, 1'b0};
    vecs[7] = '{8'h0A, 8'h0A, 1'b0};
    vecs[8] = '{8'h0D, 8'h0D, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_err = 1'b0;
    r_in_valid = 1'b0; r_in_data = 8'h00; r_in_err = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_error", 32'(out_err), 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // First byte: valid appears exactly two cycles after acceptance.
    send(1'b0, 8'h61, 1'b0);
    exp_q.push_back(8'h41);
    idle();
    @(negedge clk);
    check("lat_n1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_n2_valid", 32'(out_valid), 32'd1);
    check("lat_n2_data", 32'(out_data), 32'h41);
    drain(50);

    for (int i = 0; i < 9; i++) begin
      send(1'b0, vecs[i].din, 1'b0);
      exp_q.push_back(vecs[i].dout);
      if (vecs[i].lf) exp_q.push_back(8'h0A);
    end
    idle();
    drain(100);

    // Pass-through instance: no case folding, no LF insertion.
    send(1'b1, 8'h0D, 1'b0); rexp_q.push_back(8'h0D);
    send(1'b1, 8'h31, 1'b0); rexp_q.push_back(8'h31);
    send(1'b1, 8'h61, 1'b0); rexp_q.push_back(8'h61);
    idle();
    drain(100);

    // Sink stalled: 16 in FIFO plus 1 in hold, then backpressure.
    ready_mode = 0;
    repeat (2) @(negedge clk);
    nacc = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_err = 1'b0; in_data = 8'h61;
    for (int c = 0; (c < 40) && (nacc < 20); c++) begin
      @(negedge clk);
      if (in_ready) begin
        expect_main(in_data);
        nacc++;
      end
      @(posedge clk);
      #1;
      in_data = 8'h61 + 8'(nacc);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("full_accepted", 32'(nacc), 32'd17);
    check("full_level", 32'(level), 32'd16);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_hold_data", 32'(out_data), 32'h41);
    ready_mode = 1;
    drain(100);

    // Errored beats are dropped and counted.
    send(1'b0, 8'h55, 1'b0); exp_q.push_back(8'h55);
    send(1'b0, 8'hAA, 1'b1);
    send(1'b0, 8'h55, 1'b0); exp_q.push_back(8'h55);
    send(1'b0, 8'h0D, 1'b1);
    send(1'b0, 8'h61, 1'b1);
    send(1'b0, 8'h55, 1'b0); exp_q.push_back(8'h55);
    idle();
    drain(50);
    check("errcnt_3", 32'(err_count), 32'd3);
    for (int i = 0; i < 300; i++) send(1'b0, 8'(i), 1'b1);
    idle();
    @(negedge clk);
    check("errcnt_sat", 32'(err_count), 32'd255);
    check("errcnt_level", 32'(level), 32'd0);

    // Reset in the middle of a stalled stream.
    ready_mode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) send(1'b0, 8'h30 + 8'(i), 1'b0);
    idle();
    @(negedge clk);
    check("pre_rst_level", 32'(level), 32'd5);
    ready_mode = 1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'h00);
    check("mid_rst_errcnt", 32'(err_count), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_level", 32'(level), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // Random throttling on both sides against the scoreboard.
    ready_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) b = 8'h0D;
      e = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) idle();
      send(1'b0, b, e);
      if (!e) expect_main(b);
    end
    idle();
    ready_mode = 1;
    drain(1000);
    check("end_level", 32'(level), 32'd0);
    check("end_error", 32'(out_err), 32'd0);
    check("raw_end_level", 32'(r_level), 32'd0);
    check("raw_end_errcnt", 32'(r_err_count), 32'd0);
    check("raw_end_error", 32'(r_out_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
